// File: rtl/switch_debouncer_pkg.sv
// Shared types and default constants for the switch conditioning path.
// The decoder and the board top level reuse the same defaults.
package switch_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    TRACK  = 1'b1
  } state_t;

  localparam int unsigned SW_WIDTH           = 2;
  localparam int unsigned DEB_CNT_W          = 16;
  localparam int unsigned DEB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw levels in, debounced code, strobe, valid and FSM state out.
// changed is a single-cycle strobe in the cycle a new switch_clean is visible.
// valid is a level that stays high from initial capture until reset.
// Neither signal has a ready, so the consumer must sample every cycle.
interface switch_debouncer_if
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_clean;
  logic             changed;
  logic             valid;
  state_t           state_dbg;

  modport master (
    output switch_raw,
    input  switch_clean,
    input  changed,
    input  valid,
    input  state_dbg
  );

  modport slave (
    input  switch_raw,
    output switch_clean,
    output changed,
    output valid,
    output state_dbg
  );

endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and clean flop.
// The bit flips after DEBOUNCE_CYCLES consecutive mismatching synchronised cycles.
module debounce_bit #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic updated,
  output logic match
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             updated_q, updated_d;
  logic             match_now;

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    clean_d   = clean_q;
    updated_d = 1'b0;
    match_now = (sync2_q == clean_q);
    // The counter is cleared on every accept, so it can never pass CNT_LAST.
    if (!match_now) begin
      if (cnt_q == CNT_LAST) begin
        clean_d   = sync2_q;
        updated_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      updated_q <= updated_d;
    end
  end

  assign clean   = clean_q;
  assign updated = updated_q;
  assign match   = match_now;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switches and flags when the initial switch state is captured.
// Change strobes are reported only after that capture completes.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned CNT_W           = DEB_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  switch_debouncer_if.slave     sw
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] clean_vec;
  logic [WIDTH-1:0] updated_vec;
  logic [WIDTH-1:0] match_vec;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (sw.switch_raw[i]),
      .clean   (clean_vec[i]),
      .updated (updated_vec[i]),
      .match   (match_vec[i])
    );
  end

  // Capture completes once every bit has agreed with its clean value for a full window.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    case (state_q)
      SETTLE: begin
        if (&match_vec) begin
          if (settle_q == SETTLE_LAST) begin
            state_d = TRACK;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      TRACK: begin
        state_d = TRACK;
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  assign sw.switch_clean = clean_vec;
  assign sw.changed      = (state_q == TRACK) && (|updated_vec);
  assign sw.valid        = (state_q == TRACK);
  assign sw.state_dbg    = state_q;

endmodule
